// File: rtl/lsu_store_demux_if.sv
// Memory-stage bus between the core and the store/load routing unit.
interface lsu_store_demux_if #(
  parameter int DMEM_AW = 13
);
  // request from the core
  logic                 st_en_i;
  logic                 ld_en_i;
  logic [31:0]          addr_i;
  logic [31:0]          wdata_i;
  logic [1:0]           size_i;
  // data memory write port
  logic                 dmem_we_o;
  logic [DMEM_AW-3:0]   dmem_addr_o;
  logic [31:0]          dmem_wdata_o;
  logic [3:0]           dmem_be_o;
  // output-peripheral registers
  logic [31:0]          ledr_o;
  logic [31:0]          ledg_o;
  logic [31:0]          hex_lo_o;
  logic [31:0]          hex_hi_o;
  // load-mux control and status
  logic [31:0]          out_rdata_o;
  logic [1:0]           rsel_o;
  logic                 rsel_vld_o;
  logic                 misalign_o;
  logic [7:0]           err_cnt_o;

  modport master (
    output st_en_i, ld_en_i, addr_i, wdata_i, size_i,
    input  dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  ledr_o, ledg_o, hex_lo_o, hex_hi_o,
    input  out_rdata_o, rsel_o, rsel_vld_o, misalign_o, err_cnt_o
  );

  modport slave (
    input  st_en_i, ld_en_i, addr_i, wdata_i, size_i,
    output dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output ledr_o, ledg_o, hex_lo_o, hex_hi_o,
    output out_rdata_o, rsel_o, rsel_vld_o, misalign_o, err_cnt_o
  );
endinterface

// File: rtl/lsu_store_demux.sv
// Store/load routing for the memory stage: decodes the region, aligns byte
// lanes, drives the DMEM write port or the output registers, and produces the
// registered select for the load-data mux.
module lsu_store_demux #(
  parameter int          DMEM_AW  = 13,
  parameter logic [31:0] OUT_BASE = 32'h1000_0000,
  parameter logic [31:0] IN_BASE  = 32'h1001_0000
) (
  input logic               clk_i,
  input logic               rst_ni,
  lsu_store_demux_if.slave  bus
);

  localparam logic [1:0] RS_DMEM = 2'b00;
  localparam logic [1:0] RS_OUT  = 2'b01;
  localparam logic [1:0] RS_IN   = 2'b10;

  logic             in_dmem, in_out, in_in, mapped;
  logic             size_bad, mis;
  logic [3:0]       be;
  logic [31:0]      lane_data;
  logic             st_ok, st_dmem, st_out, st_err;
  logic             ld_act, ld_err, err_ev, mis_ev;
  logic [1:0]       rsel_code;
  logic [1:0]       idx;
  logic [3:0][31:0] out_q;

  assign idx = bus.addr_i[3:2];

  // region decode, alignment check and lane steering for the current request
  always_comb begin
    in_dmem   = (bus.addr_i[31:DMEM_AW] == '0);
    in_out    = (bus.addr_i[31:4] == OUT_BASE[31:4]);
    in_in     = (bus.addr_i[31:4] == IN_BASE[31:4]);
    mapped    = in_dmem | in_out | in_in;
    size_bad  = (bus.size_i == 2'b11);
    mis       = ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                ((bus.size_i == 2'b10) && (bus.addr_i[1:0] != 2'b00));
    be        = 4'b0000;
    lane_data = bus.wdata_i;
    case (bus.size_i)
      2'b00: begin
        be        = 4'b0001 << bus.addr_i[1:0];
        lane_data = {4{bus.wdata_i[7:0]}};
      end
      2'b01: begin
        be        = bus.addr_i[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{bus.wdata_i[15:0]}};
      end
      2'b10: be = 4'b1111;
      default: be = 4'b0000;
    endcase

    // IN is read-only, so a store only lands in DMEM or OUT
    st_ok   = bus.st_en_i && !size_bad && !mis && (in_dmem || in_out);
    st_dmem = st_ok && in_dmem;
    st_out  = st_ok && in_out;
    st_err  = bus.st_en_i && !st_ok;

    // a store in the same cycle wins; the load is discarded
    ld_act  = bus.ld_en_i && !bus.st_en_i;
    ld_err  = ld_act && (size_bad || mis || !mapped);

    err_ev  = st_err || ld_err || (bus.st_en_i && bus.ld_en_i);
    mis_ev  = (bus.st_en_i || ld_act) && mis;

    rsel_code = RS_DMEM;
    if (!ld_err) begin
      if (in_out)     rsel_code = RS_OUT;
      else if (in_in) rsel_code = RS_IN;
    end
  end

  // DMEM write port: one-cycle strobe following each accepted store
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.dmem_we_o    <= 1'b0;
      bus.dmem_addr_o  <= '0;
      bus.dmem_wdata_o <= '0;
      bus.dmem_be_o    <= '0;
    end else begin
      bus.dmem_we_o <= st_dmem;
      if (st_dmem) begin
        bus.dmem_addr_o  <= bus.addr_i[DMEM_AW-1:2];
        bus.dmem_wdata_o <= lane_data;
        bus.dmem_be_o    <= be;
      end
    end
  end

  // output registers: byte-lane write into the addressed register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (st_out) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) out_q[idx][b*8 +: 8] <= lane_data[b*8 +: 8];
    end
  end

  assign bus.ledr_o   = out_q[0];
  assign bus.ledg_o   = out_q[1];
  assign bus.hex_lo_o = out_q[2];
  assign bus.hex_hi_o = out_q[3];

  // load select and readback; readback sees the value before this edge's write
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.rsel_o      <= RS_DMEM;
      bus.rsel_vld_o  <= 1'b0;
      bus.out_rdata_o <= '0;
    end else begin
      bus.rsel_vld_o <= ld_act;
      if (ld_act) begin
        bus.rsel_o <= rsel_code;
        if (rsel_code == RS_OUT) bus.out_rdata_o <= out_q[idx];
      end
    end
  end

  // sticky misalign flag and saturating error counter
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.misalign_o <= 1'b0;
      bus.err_cnt_o  <= '0;
    end else begin
      if (mis_ev) bus.misalign_o <= 1'b1;
      if (err_ev && (bus.err_cnt_o != 8'hFF)) bus.err_cnt_o <= bus.err_cnt_o + 8'd1;
    end
  end

endmodule

// File: doc/lsu_store_demux.md
Name: lsu_store_demux

Overview:
- Store/load routing unit for the single-cycle core's memory stage.
- Splits one store request from the core three ways: data memory write port, the output-peripheral register bank, or drop with error. Performs byte-lane alignment on the way.
- On loads, generates the registered 2-bit source select (plus output-register readback data) that drives the load-data 3:1 mux.

Parameters:
- DMEM_AW, 13: byte-address width of data memory (8 KiB); the region is 0 to 2^DMEM_AW-1.
- OUT_BASE, 32'h1000_0000: base of output-register region (4 words).
- IN_BASE, 32'h1001_0000: base of input-peripheral region (read-only, 4 words).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  synchronous active-low reset
- st_en_i  in  1  store request this cycle
- ld_en_i  in  1  load request this cycle
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-justified
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- dmem_we_o  out  1  data memory write strobe
- dmem_addr_o  out  DMEM_AW-2  data memory word address
- dmem_wdata_o  out  32  lane-aligned write data
- dmem_be_o  out  4  byte enables
- ledr_o, ledg_o, hex_lo_o, hex_hi_o  out  32 each  output registers, indices 0..3
- out_rdata_o  out  32  readback of addressed output register
- rsel_o  out  2  load-mux select: 00 DMEM, 01 OUT, 10 IN
- rsel_vld_o  out  1  rsel_o/out_rdata_o valid
- misalign_o  out  1  sticky misaligned-access flag
- err_cnt_o  out  8  saturating error counter

Behaviour:
- Reset: when rst_ni=0 at a clock edge, every output and register clears to 0. This includes the output registers, misalign_o and err_cnt_o. Reset overrides any request in the same cycle.
- Region decode (combinational on addr_i):
  - DMEM when addr_i < 2^DMEM_AW.
  - OUT when addr_i[31:4] == OUT_BASE[31:4]; register index = addr_i[3:2].
  - IN when addr_i[31:4] == IN_BASE[31:4].
  - Anything else is unmapped.
- Alignment:
  - Half with addr_i[0]=1 is misaligned.
  - Word with addr_i[1:0]!=0 is misaligned.
  - Misaligned access performs no write, sets misalign_o (sticky until reset) and increments err_cnt_o.
- Lane rules:
  - Byte: be = 1<<addr_i[1:0]; data = {4{wdata_i[7:0]}}.
  - Half: be = addr_i[1] ? 1100 : 0011; data = {2{wdata_i[15:0]}}.
  - Word: be = 1111; data = wdata_i.
- Store to DMEM:
  - Request sampled at edge N.
  - During cycle N+1: dmem_we_o=1 with dmem_addr_o = addr_i[DMEM_AW-1:2], dmem_be_o, dmem_wdata_o.
  - dmem_we_o returns to 0 the following cycle unless a new store arrives. Back-to-back stores give continuous we.
- Store to OUT: the selected register updates only in enabled byte lanes at edge N; the new value is visible on its port in cycle N+1.
- Dropped stores: stores to IN, unmapped addresses, or size_i=11 write nothing and increment err_cnt_o.
- Load:
  - Request sampled at edge N.
  - In cycle N+1: rsel_vld_o=1, rsel_o = region code.
  - For OUT, out_rdata_o = register value before any same-edge update (full word; the core extracts lanes).
  - Unmapped, misaligned or illegal-size loads: rsel_o=00, rsel_vld_o=1, err_cnt_o increments; misaligned loads also set misalign_o.
  - With no load in a cycle, rsel_vld_o=0 next cycle and rsel_o holds its last value.
- Simultaneous st_en_i and ld_en_i: the store executes, the load is ignored (rsel_vld_o=0), and err_cnt_o increments.
- err_cnt_o: increments by at most 1 per cycle, saturates at 255 and never wraps.

Test Plan:
- Reset then idle: all outputs 0 after rst_ni=0 for one edge; assert rst_ni=0 during a store -> no write occurs and err_cnt_o stays 0.
- Store byte 0xA5 to addr 0x0000_0102 -> next cycle dmem_we_o=1, dmem_addr_o=0x040, be=0100, wdata=0xA5A5A5A5; following cycle dmem_we_o=0.
- Store word 0x1234_5678 to 0x1000_0004, then half 0xBEEF to 0x1000_0006 -> ledg_o=0x1234_5678, then 0xBEEF_5678; load 0x1000_0004 -> rsel_o=01, out_rdata_o=0xBEEF_5678.
- Word store to 0x0000_0013 and half store to 0x1000_0001 -> no write anywhere, misalign_o=1, err_cnt_o=2.
- Store to 0x1001_0000, store to 0x2000_0000, size_i=11 store -> all dropped, err_cnt_o=3; load from 0x1001_0008 -> rsel_o=10, rsel_vld_o=1.
- 260 consecutive unmapped loads -> err_cnt_o saturates at 255; simultaneous st/ld to 0x0000_0000 -> store occurs, rsel_vld_o=0 next cycle.
